cpu64_l1i_refill: RTL and testbench



---
 rtl/cpu64_l1i_pkg.sv | 27 ++
 rtl/cpu64_l1i_refill_if.sv | 23 ++
 rtl/cpu64_l1i_victim_sel.sv | 20 ++
 rtl/cpu64_l1i_refill.sv | 151 +++++++++++++++
 tb/tb_cpu64_l1i_refill.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu64_l1i_pkg.sv
// rtl/cpu64_l1i_pkg.sv - L1I refill geometry, address field offsets and FSM state type
package cpu64_l1i_pkg;

  localparam int WAYS           = 8;
  localparam int SETS           = 64;
  localparam int WORDS_PER_LINE = 8;
  localparam int TAG_W          = 52;
  localparam int DATA_W         = 64;
  localparam int ADDR_W         = 64;

  localparam int WAY_W   = $clog2(WAYS);
  localparam int INDEX_W = $clog2(SETS);
  localparam int WORD_W  = $clog2(WORDS_PER_LINE);

  localparam int WORD_LSB  = 3;
  localparam int INDEX_LSB = WORD_LSB + WORD_W;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_WLAST = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/cpu64_l1i_refill_if.sv
// rtl/cpu64_l1i_refill_if.sv - line request / beat response bus to the next level
interface cpu64_l1i_refill_if;
  import cpu64_l1i_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_err;
  logic              mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_addr, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

endinterface

// File: rtl/cpu64_l1i_victim_sel.sv
// rtl/cpu64_l1i_victim_sel.sv - victim way: lowest invalid way, else round-robin pointer
module cpu64_l1i_victim_sel
  import cpu64_l1i_pkg::*;
(
  input  logic [WAYS-1:0]  valid_way_i,
  input  logic [WAY_W-1:0] rr_i,
  output logic [WAY_W-1:0] way_o,
  output logic             all_valid_o
);

  always_comb begin
    way_o       = rr_i;
    all_valid_o = &valid_way_i;
    // Descending scan so the lowest-numbered invalid way wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_way_i[i]) way_o = WAY_W'(i);
    end
  end

endmodule

// File: rtl/cpu64_l1i_refill.sv
// rtl/cpu64_l1i_refill.sv - L1I line refill engine; CPU64_L1I_CRITICAL_WORD_FIRST_EN selects
// critical-word-first request/beat order, otherwise line-aligned order 0..7.
module cpu64_l1i_refill
  import cpu64_l1i_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               miss_valid_i,
  input  logic [ADDR_W-1:0]  miss_addr_i,
  output logic               miss_ready_o,
  input  logic [WAYS-1:0]    valid_way_i,
  cpu64_l1i_refill_if.master mem,
  output logic [INDEX_W-1:0] index_o,
  output logic [WORD_W-1:0]  word_sel_o,
  output logic [WAY_W-1:0]   way_sel_o,
  output logic               write_en_o,
  output logic               set_valid_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               crit_valid_o,
  output logic [DATA_W-1:0]  crit_data_o,
  output logic               refill_done_o,
  output logic               refill_err_o,
  output logic               busy_o
);

  state_e state_q, state_d;

  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WORD_W-1:0]  crit_q, cnt_q, start_word, beat_word;
  logic [WAY_W-1:0]   way_q, rr_q, victim_way;
  logic               all_valid, err_q, kill_q;
  logic               wr_pend_q, wr_last_q, wr_crit_q;
  logic [WORD_W-1:0]  wr_word_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic               accept, beat_acc;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^miss_addr_i[WORD_LSB-1:0];

`ifdef CPU64_L1I_CRITICAL_WORD_FIRST_EN
  assign start_word = crit_q;
`else
  assign start_word = '0;
`endif

  assign accept    = miss_ready_o && miss_valid_i;
  assign beat_acc  = (state_q == S_RESP) && mem.mem_rsp_valid;
  assign beat_word = start_word + cnt_q;

  cpu64_l1i_victim_sel u_victim_sel (
    .valid_way_i (valid_way_i),
    .rr_i        (rr_q),
    .way_o       (victim_way),
    .all_valid_o (all_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    miss_ready_o      = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_rsp_ready = 1'b0;
    refill_done_o     = 1'b0;
    refill_err_o      = 1'b0;
    busy_o            = 1'b1;
    index_o           = index_q;
    unique case (state_q)
      S_IDLE: begin
        busy_o       = 1'b0;
        miss_ready_o = !rst_i;
        // Drive the miss index straight through so valid_way_i is usable in the accept cycle.
        index_o      = rst_i ? '0 : miss_addr_i[INDEX_LSB +: INDEX_W];
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        mem.mem_rsp_ready = 1'b1;
        if (mem.mem_rsp_valid && cnt_q == WORD_W'(WORDS_PER_LINE - 1)) state_d = S_WLAST;
      end
      S_WLAST: state_d = S_DONE;
      S_DONE: begin
        refill_done_o = 1'b1;
        refill_err_o  = err_q && !kill_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_q   <= '0;
      tag_q     <= '0;
      crit_q    <= '0;
      way_q     <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      kill_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_last_q <= 1'b0;
      wr_crit_q <= 1'b0;
      wr_word_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_pend_q <= beat_acc;
      if (accept) begin
        index_q <= miss_addr_i[INDEX_LSB +: INDEX_W];
        tag_q   <= miss_addr_i[TAG_LSB +: TAG_W];
        crit_q  <= miss_addr_i[WORD_LSB +: WORD_W];
        way_q   <= victim_way;
        if (all_valid) rr_q <= rr_q + WAY_W'(1);
        cnt_q   <= '0;
        err_q   <= 1'b0;
        kill_q  <= 1'b0;
      end
      if (flush_i && busy_o) kill_q <= 1'b1;
      if (beat_acc) begin
        cnt_q     <= cnt_q + WORD_W'(1);
        err_q     <= err_q | mem.mem_rsp_err;
        wr_word_q <= beat_word;
        wr_data_q <= mem.mem_rsp_data;
        wr_last_q <= (cnt_q == WORD_W'(WORDS_PER_LINE - 1));
        wr_crit_q <= (beat_word == crit_q);
      end
    end
  end

  assign mem.mem_req_addr = {tag_q, index_q, start_word, 3'b000};

  // Killed refills still drain their beats, but nothing reaches the arrays or fetch.
  assign write_en_o   = wr_pend_q && !kill_q;
  assign set_valid_o  = write_en_o && wr_last_q && !err_q;
  assign crit_valid_o = write_en_o && wr_crit_q;
  assign crit_data_o  = crit_valid_o ? wr_data_q : '0;
  assign word_sel_o   = wr_word_q;
  assign way_sel_o    = way_q;
  assign tag_o        = tag_q;
  assign wdata_o      = wr_data_q;

endmodule

// File: tb/tb_cpu64_l1i_refill.sv
// tb/tb_cpu64_l1i_refill.sv - randomized refill bench against a line-level reference model
module tb_cpu64_l1i_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        miss_valid;
  logic [63:0] miss_addr;
  logic        miss_ready;
  logic [7:0]  valid_way;
  logic [5:0]  index_o;
  logic [2:0]  word_sel;
  logic [2:0]  way_sel;
  logic        write_en;
  logic        set_valid;
  logic [51:0] tag_o;
  logic [63:0] wdata;
  logic        crit_valid;
  logic [63:0] crit_data;
  logic        refill_done;
  logic        refill_err;
  logic        busy;

  cpu64_l1i_refill_if mem_if ();

  cpu64_l1i_refill dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .miss_valid_i  (miss_valid),
    .miss_addr_i   (miss_addr),
    .miss_ready_o  (miss_ready),
    .valid_way_i   (valid_way),
    .mem           (mem_if),
    .index_o       (index_o),
    .word_sel_o    (word_sel),
    .way_sel_o     (way_sel),
    .write_en_o    (write_en),
    .set_valid_o   (set_valid),
    .tag_o         (tag_o),
    .wdata_o       (wdata),
    .crit_valid_o  (crit_valid),
    .crit_data_o   (crit_data),
    .refill_done_o (refill_done),
    .refill_err_o  (refill_err),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_model = 0;
`ifdef CPU64_L1I_CRITICAL_WORD_FIRST_EN
  bit cwf = 1'b1;
`else
  bit cwf = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One full miss: accept, request, eight beats, done. err_beat/flush_beat/rst_beat < 0 disable.
  task automatic do_refill(input logic [63:0] addr, input logic [7:0] vway, input int err_beat,
                           input int flush_beat, input int rst_beat, input bit gaps);
    logic [63:0] data [8];
    logic [63:0] exp_req;
    logic [2:0]  crit_w, start, w;
    int          exp_way, sent, pend, cyc, d;
    bit          killed, any_err, v, fl, full;

    for (int k = 0; k < 8; k++) data[k] = {$urandom, $urandom};
    crit_w  = addr[5:3];
    start   = cwf ? crit_w : 3'd0;
    exp_req = {addr[63:6], start, 3'b000};
    exp_way = -1;
    for (int i = 0; i < 8; i++) if (!vway[i] && exp_way < 0) exp_way = i;
    full = (exp_way < 0);
    if (full) exp_way = rr_model;

    @(negedge clk);
    miss_valid = 1'b1; miss_addr = addr; valid_way = vway;
    #1;
    chk("miss_ready_idle", miss_ready, 1);
    chk("index_idle", index_o, addr[11:6]);
    if (full) rr_model = (rr_model + 1) % 8;

    @(negedge clk);
    miss_valid = 1'b0; miss_addr = {$urandom, $urandom}; valid_way = 8'($urandom);
    #1;
    chk("busy_req", busy, 1);
    chk("miss_ready_busy", miss_ready, 0);

    d = gaps ? $urandom_range(0, 2) : 0;
    for (int i = 0; i <= d; i++) begin
      chk("req_valid", mem_if.mem_req_valid, 1);
      chk("req_addr", mem_if.mem_req_addr, exp_req);
      mem_if.mem_req_ready = (i == d);
      @(negedge clk);
      mem_if.mem_req_ready = 1'b0;
      #1;
    end
    chk("req_valid_drop", mem_if.mem_req_valid, 0);

    sent = 0; pend = -1; killed = 0; any_err = 0; cyc = 0;
    forever begin
      w = start + 3'(pend);
      chk("wr_en", write_en, pend >= 0 && !killed);
      chk("crit_valid", crit_valid, pend >= 0 && !killed && w == crit_w);
      if (pend >= 0 && !killed) begin
        chk("wr_word", word_sel, w);
        chk("wr_data", wdata, data[pend]);
        chk("wr_way", way_sel, exp_way);
        chk("wr_index", index_o, addr[11:6]);
        chk("wr_tag", tag_o, addr[63:12]);
        chk("set_valid", set_valid, pend == 7 && !any_err);
        if (w == crit_w) chk("crit_data", crit_data, data[pend]);
      end
      if (pend == 7) break;
      chk("rsp_ready", mem_if.mem_rsp_ready, 1);
      if (rst_beat >= 0 && sent == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_wr_en", write_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_ready", mem_if.mem_rsp_ready, 0);
        chk("rst_miss_ready", miss_ready, 0);
        @(negedge clk);
        rst = 1'b0; rr_model = 0;
        #1;
        chk("miss_ready_after_rst", miss_ready, 1);
        return;
      end
      fl = (flush_beat >= 0 && pend == flush_beat);
      flush = fl;
      v = (sent < 8) && (!gaps || $urandom_range(0, 3) != 0);
      mem_if.mem_rsp_valid = v;
      mem_if.mem_rsp_data  = v ? data[sent] : {$urandom, $urandom};
      mem_if.mem_rsp_err   = v && (sent == err_beat);
      if (v && sent == err_beat) any_err = 1;
      pend = v ? sent : -1;
      if (v) sent++;
      @(negedge clk);
      flush = 1'b0; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_err = 1'b0;
      if (fl) killed = 1;
      #1;
      cyc++;
      if (cyc > 100) begin
        chk("resp_timeout", 1, 0);
        return;
      end
    end
    chk("rsp_ready_wlast", mem_if.mem_rsp_ready, 0);
    chk("done_early", refill_done, 0);

    @(negedge clk);
    #1;
    chk("done", refill_done, 1);
    chk("err", refill_err, any_err && !killed);
    chk("wr_en_done", write_en, 0);
    chk("busy_done", busy, 1);

    @(negedge clk);
    #1;
    chk("miss_ready_after", miss_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; miss_valid = 1'b0; miss_addr = 64'hFFFF_FFFF_FFFF_FFC0;
    valid_way = 8'h00;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_data = '0; mem_if.mem_rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_miss_ready", miss_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_index", index_o, 0);
    chk("rst_req_valid", mem_if.mem_req_valid, 0);
    chk("rst_wr_en", write_en, 0);
    chk("rst_done", refill_done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("miss_ready_first", miss_ready, 1);

    do_refill(64'h0000_0000_0000_1048, 8'h00, -1, -1, -1, 0);
    do_refill({$urandom, $urandom}, 8'hFF, -1, -1, -1, 0);
    do_refill({$urandom, $urandom}, 8'hFF, -1, -1, -1, 0);
    do_refill({$urandom, $urandom}, 8'hFF, -1, -1, -1, 0);
    do_refill({$urandom, $urandom}, 8'hFB, -1, -1, -1, 0);
    do_refill({$urandom, $urandom}, 8'hFF, -1, -1, -1, 0);
    do_refill(64'h0000_00AB_CDE0_0068, 8'h0F, -1, -1, -1, 0);
    do_refill({$urandom, $urandom}, 8'h01, 3, -1, -1, 0);
    do_refill(64'h0000_0000_0000_1068, 8'h00, -1, 2, -1, 0);
    do_refill({$urandom, $urandom}, 8'hFF, -1, -1, 4, 0);
    do_refill({$urandom, $urandom}, 8'hFF, -1, -1, -1, 0);

    for (int t = 0; t < 30; t++) begin
      logic [7:0] vw;
      int eb, fb;
      vw = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("idle_flush_busy", busy, 0);
      end
      do_refill({$urandom, $urandom}, vw, eb, fb, -1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
